// File: rtl/lzc_pkg.sv
// Shared constants and width helpers for the pipelined leading-zero counter.
package lzc_pkg;

  localparam int LZC_N = 32;

  function automatic int lzc_levels(input int n);
    return $clog2(n);
  endfunction

  function automatic int lzc_cw(input int n);
    return $clog2(n) + 1;
  endfunction

  // Stage s holds n/2^(s+1) fields of s+2 bits each.
  function automatic int lzc_stage_w(input int n, input int s);
    return (n >> (s + 1)) * (s + 2);
  endfunction

  function automatic int lzc_stage_off(input int n, input int s);
    int off;
    off = 0;
    for (int k = 0; k < s; k++) off += lzc_stage_w(n, k);
    return off;
  endfunction

  typedef logic [lzc_cw(LZC_N)-1:0] lzc_count_t;

  // Bit pair -> 2-bit count of leading zeros, MSB doubling as the all-zero flag.
  function automatic logic [1:0] lzc_enc(input logic [1:0] p);
    logic [1:0] r;
    if (p[1])      r = 2'b00;
    else if (p[0]) r = 2'b01;
    else           r = 2'b10;
    return r;
  endfunction

endpackage

// File: rtl/lzc_level.sv
// One combinational merge level: pairs of FW-bit partial counts become FW+1-bit counts.
module lzc_level #(
  parameter int FIELDS = 1,
  parameter int FW     = 2
) (
  input  logic [2*FIELDS*FW-1:0]   din,
  output logic [FIELDS*(FW+1)-1:0] dout
);

  for (genvar i = 0; i < FIELDS; i++) begin : g_pair
    logic [FW-1:0] hi;
    logic [FW-1:0] lo;
    assign lo = din[(2*i)*FW +: FW];
    assign hi = din[(2*i+1)*FW +: FW];
    // A hi field with ones decides alone; an all-zero hi adds its full width to lo.
    assign dout[i*(FW+1) +: FW+1] = hi[FW-1] ? {lo[FW-1], ~lo[FW-1], lo[FW-2:0]}
                                             : {2'b00, hi[FW-2:0]};
  end

endmodule

// File: rtl/lzc_pipe.sv
// Pipelined valid/ready leading-zero counter; one register stage per tree level.
// Optional out_zero port enabled by defining LZC_ZERO_FLAG_EN.
module lzc_pipe
  import lzc_pkg::*;
#(
  parameter  int N  = LZC_N,
  localparam int L  = lzc_levels(N),
  localparam int CW = L + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count
`ifdef LZC_ZERO_FLAG_EN
  ,
  output logic          out_zero
`endif
);

  localparam int TOT = lzc_stage_off(N, L);

  logic [L-1:0]   vld_p;
  logic [TOT-1:0] stg_p;
  logic           adv;

  // Global stall: the whole pipe moves only when the output slot frees up.
  assign adv      = out_ready | ~vld_p[L-1];
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (reset)    vld_p <= '0;
    else if (adv) vld_p <= {vld_p[L-2:0], in_valid};
  end

  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam int W   = lzc_stage_w(N, s);
    localparam int OFF = lzc_stage_off(N, s);

    logic [W-1:0] nxt;
    logic [W-1:0] q;

    // stage boundary: level s logic feeds register q of stage s
    if (s == 0) begin : g_enc
      for (genvar i = 0; i < N/2; i++) begin : g_bit
        assign nxt[2*i +: 2] = lzc_enc(in_data[2*i +: 2]);
      end
    end else begin : g_merge
      localparam int PW   = lzc_stage_w(N, s-1);
      localparam int POFF = lzc_stage_off(N, s-1);
      lzc_level #(.FIELDS(N >> (s+1)), .FW(s+1)) u_level (
        .din  (stg_p[POFF +: PW]),
        .dout (nxt)
      );
    end

    always_ff @(posedge clk) begin
      if (reset)    q <= '0;
      else if (adv) q <= nxt;
    end

    assign stg_p[OFF +: W] = q;
  end

  assign out_valid = vld_p[L-1];
  assign out_count = stg_p[TOT-1 -: CW];

`ifdef LZC_ZERO_FLAG_EN
  assign out_zero = vld_p[L-1] & stg_p[TOT-1];
`endif

endmodule
